// File: rtl/exe_muldiv_if.sv
// Operand/result bundle between the execute stage and the mul/div unit.
// The master drives the op request; the slave returns busy, stall and HI/LO.
interface exe_muldiv_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/exe_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO for the execute stage.
// Define MD_MADD_EN to enable madd/maddu accumulate ops (7 and 8).
module exe_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    exe_muldiv_if.slave md
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] MC = 5'(MULT_CYCLES);
    localparam logic [4:0] DC = 5'(DIV_CYCLES);

    state_t      state;
    logic [4:0]  count;
    logic [63:0] shadow;
    logic        shadow_wr;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic op_mult, op_multu, op_div, op_divu;
    logic op_mthi, op_mtlo, op_madd, op_maddu;
    logic op_md, op_long;

    assign op_mult  = md.op == 4'd1;
    assign op_multu = md.op == 4'd2;
    assign op_div   = md.op == 4'd3;
    assign op_divu  = md.op == 4'd4;
    assign op_mthi  = md.op == 4'd5;
    assign op_mtlo  = md.op == 4'd6;
`ifdef MD_MADD_EN
    assign op_madd  = md.op == 4'd7;
    assign op_maddu = md.op == 4'd8;
`else
    assign op_madd  = 1'b0;
    assign op_maddu = 1'b0;
`endif
    assign op_long = op_div | op_divu;
    assign op_md   = op_mult | op_multu | op_long | op_madd | op_maddu;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, dv_u;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        div_zero;

    assign prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
    assign prod_u = {32'd0, md.a} * {32'd0, md.b};

    // Divisor forced to 1 on b==0 so no X escapes; that result is never written.
    assign div_zero = md.b == 32'd0;
    assign dv_u     = div_zero ? 32'd1 : md.b;
    assign abs_a    = md.a[31] ? -md.a : md.a;
    assign abs_b    = md.b[31] ? -md.b : dv_u;
    assign q_mag    = abs_a / abs_b;
    assign r_mag    = abs_a % abs_b;
    assign q_s      = (md.a[31] ^ md.b[31]) ? -q_mag : q_mag;
    assign r_s      = md.a[31] ? -r_mag : r_mag;
    assign q_u      = md.a / dv_u;
    assign r_u      = md.a % dv_u;

    logic [63:0] md_res;
    logic        md_wr;

    always_comb begin
        md_res = 64'd0;
        md_wr  = 1'b0;
        unique case (1'b1)
            op_mult:  begin md_res = prod_s; md_wr = 1'b1; end
            op_multu: begin md_res = prod_u; md_wr = 1'b1; end
            op_div:   begin md_res = {r_s, q_s}; md_wr = !div_zero; end
            op_divu:  begin md_res = {r_u, q_u}; md_wr = !div_zero; end
            op_madd:  begin md_res = {hi_q, lo_q} + prod_s; md_wr = 1'b1; end
            op_maddu: begin md_res = {hi_q, lo_q} + prod_u; md_wr = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            count     <= 5'd0;
            shadow    <= 64'd0;
            shadow_wr <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (md.start) begin
                        if (op_md) begin
                            shadow    <= md_res;
                            shadow_wr <= md_wr;
                            count     <= op_long ? DC : MC;
                            state     <= RUN;
                            busy_q    <= 1'b1;
                        end else if (op_mthi) begin
                            hi_q <= md.a;
                        end else if (op_mtlo) begin
                            lo_q <= md.a;
                        end
                    end
                end
                RUN: begin
                    if (count == 5'd1) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        count  <= 5'd0;
                        if (shadow_wr) {hi_q, lo_q} <= shadow;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
            endcase
        end
    end

    assign md.busy      = busy_q;
    assign md.stall_req = busy_q | (md.start & op_md);
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Multi-cycle multiply/divide unit in the Execute stage, downstream of the decode/execute pipeline register.
- Consumes forwarded rs/rt operands plus a decoded op code.
- Owns the architectural HI/LO registers for mult/multu/div/divu/mthi/mtlo.
- Drives a busy/stall request back to the hazard unit so mfhi/mflo and further md ops stall until results are ready.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..31
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  op valid this cycle; sampled on clk rising edge
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; 9-15 no-op
- a  input  32  rs operand, already forwarded
- b  input  32  rt operand, already forwarded
- busy  output  1  computation in progress
- stall_req  output  1  combinational: busy | (start & op in {1,2,3,4,7,8})
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (async, immediate): hi=0, lo=0, busy=0, state=IDLE, counter=0, shadow result regs=0. Reset mid-operation aborts the op; no HI/LO write follows.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE, start=1, op in {1,2,3,4,7,8}, edge T:
  - Latch the computed 64-bit result in shadow regs.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy is high from after T through edge T+N; hi/lo update at edge T+N, and busy=0 at that edge.
  - busy is therefore high for exactly N cycles.
  - hi/lo keep their old values during RUN.
- IDLE, start=1, op=5 (mthi) or 6 (mtlo): hi (or lo) <= a at that edge; busy stays 0.
- start in RUN is ignored entirely, including mthi/mtlo. The hazard unit guarantees it never happens; the bench checks that it is ignored.
- Arithmetic:
  - mult: signed 32x32 -> 64; {hi,lo} = product.
  - multu: unsigned 32x32 -> 64; {hi,lo} = product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b=0): op still occupies DIV_CYCLES with busy=1; hi/lo unchanged at completion.
- Operands are captured at the start edge; later changes on a/b during RUN have no effect.
- op 0 or 9-15 with start=1: no state change.
- Back-to-back: a new start is accepted in the cycle after busy falls, i.e. the edge T+N+1 at the earliest.

Optional Feature:
- MD_MADD_EN defined:
  - op 7 (madd): {hi,lo} <= {hi,lo} + signed(a)*signed(b), modulo 2^64.
  - op 8 (maddu): {hi,lo} <= {hi,lo} + unsigned(a)*unsigned(b), modulo 2^64.
  - Both use MULT_CYCLES latency.
  - The accumulate base is the HI/LO value at the start edge.
- MD_MADD_EN undefined: ops 7 and 8 are no-ops (no busy, no HI/LO change), and stall_req excludes them.

Test Plan:
- Signed multiply: start, op=1, a=0xFFFFFFFF, b=0x00000002 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged while busy.
- Unsigned multiply and unsigned divide:
  - op=2, a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
  - op=4, a=7, b=2 -> lo=3, hi=1 after 10 busy cycles.
- Signed divide and divide by zero:
  - op=3, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - op=3, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - op=3, a=5, b=0 -> busy 10 cycles, hi/lo unchanged.
- Move ops and ignored start:
  - op=5, a=0x12345678 -> hi=0x12345678 next edge, busy never high.
  - During a running mult, apply op=6 with a=0xDEADBEEF -> lo unaffected; final lo equals the product low word.
- Reset mid-op: start div a=100, b=3; assert reset at cycle 4 -> hi=lo=0 and busy=0 immediately, with no later update; a following mult 3*4 gives lo=12, hi=0.
- MD_MADD_EN: mthi 0, mtlo 0xFFFFFFFF, then madd a=1, b=1 -> hi=1, lo=0. With the macro undefined, the same sequence leaves hi=0, lo=0xFFFFFFFF, and busy stays 0.
